mem_ctrl: RTL

Memory controller between the core's two memory clients and the byte-wide unified RAM/IO bus. It serves 64-byte instruction-block reads for the fetch stage's I-cache refill, and 1/2/4-byte loads and stores for the load/store buffer. It serialises every transaction into one byte per cycle and returns assembled data with a one-cycle done pulse.

---
 rtl/mem_ctrl_if.sv | 35 +++
 rtl/mem_ctrl.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl_if.sv
// rtl/mem_ctrl_if.sv - client request/response and byte-bus bundle for mem_ctrl
interface mem_ctrl_if #(
  parameter int IF_BYTES = 64
);
  logic                  if_en;
  logic [31:0]           if_pc;
  logic                  if_done;
  logic [IF_BYTES*8-1:0] if_data;

  logic                  lsb_en;
  logic                  lsb_wr;
  logic [31:0]           lsb_addr;
  logic [1:0]            lsb_len;
  logic [31:0]           lsb_wdata;
  logic                  lsb_done;
  logic [31:0]           lsb_rdata;

  logic [7:0]            mem_din;
  logic [7:0]            mem_dout;
  logic [31:0]           mem_a;
  logic                  mem_wr;
  logic                  io_buffer_full;

  modport slave (
    input  if_en, if_pc, lsb_en, lsb_wr, lsb_addr, lsb_len, lsb_wdata,
    input  mem_din, io_buffer_full,
    output if_done, if_data, lsb_done, lsb_rdata, mem_dout, mem_a, mem_wr
  );

  modport master (
    output if_en, if_pc, lsb_en, lsb_wr, lsb_addr, lsb_len, lsb_wdata,
    output mem_din, io_buffer_full,
    input  if_done, if_data, lsb_done, lsb_rdata, mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - byte-serial memory controller for I-cache block reads and LSB loads/stores
module mem_ctrl #(
  parameter int          IF_BYTES = 64,
  parameter logic [31:0] IO_ADDR  = 32'h30000
) (
  input  logic      i_clk,
  input  logic      i_rst_n,
  input  logic      i_rdy,
  mem_ctrl_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_COOL} state_t;

  localparam logic [6:0] FETCH_LEN = 7'(IF_BYTES);
  localparam int         IDX_W     = $clog2(IF_BYTES);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [6:0]            r_cnt;
  logic [6:0]            r_len;
  logic [31:0]           r_base;
  logic [31:0]           r_wdata;
  logic                  r_is_lsb;
  logic [IF_BYTES*8-1:0] r_if_data;
  logic [31:0]           r_lsb_rdata;
  logic                  r_if_done;
  logic                  r_lsb_done;
  logic [31:0]           r_mem_a;
  logic [7:0]            r_mem_dout;
  logic                  r_mem_wr;

  logic                  w_owner_en;
  logic                  w_last;
  logic                  w_stall;
  logic                  w_accept;
  logic                  w_capture;
  logic [6:0]            w_lsb_len;
  logic [IDX_W-1:0]      w_byte_idx;
  logic [6:0]            w_cnt_nxt;
  logic [31:0]           w_mem_a_nxt;
  logic [7:0]            w_mem_dout_nxt;
  logic                  w_mem_wr_nxt;
  logic                  w_if_done_nxt;
  logic                  w_lsb_done_nxt;

  assign w_owner_en = r_is_lsb ? bus.lsb_en : bus.if_en;
  assign w_last     = (r_cnt == r_len);
  assign w_stall    = bus.io_buffer_full && (r_base >= IO_ADDR);
  assign w_accept   = (r_state == S_IDLE) && (bus.lsb_en || bus.if_en);
  assign w_lsb_len  = (bus.lsb_len == 2'd0) ? 7'd1 : (bus.lsb_len == 2'd1) ? 7'd2 : 7'd4;
  assign w_byte_idx = IDX_W'(r_cnt - 7'd1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else if (i_rdy) begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.lsb_en)     w_state_nxt = bus.lsb_wr ? S_WRITE : S_READ;
        else if (bus.if_en) w_state_nxt = S_READ;
      end
      S_READ: begin
        if (!w_owner_en)    w_state_nxt = S_IDLE;
        else if (w_last)    w_state_nxt = S_COOL;
      end
      S_WRITE: begin
        if (w_last)         w_state_nxt = S_COOL;
      end
      default:              w_state_nxt = S_IDLE;
    endcase
  end

  // Bus outputs are registered one step ahead: the value for cnt+1 is computed while cnt is current.
  always_comb begin
    w_cnt_nxt      = r_cnt;
    w_mem_a_nxt    = 32'd0;
    w_mem_dout_nxt = r_mem_dout;
    w_mem_wr_nxt   = 1'b0;
    w_if_done_nxt  = 1'b0;
    w_lsb_done_nxt = 1'b0;
    w_capture      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = 7'd0;
        if (bus.lsb_en) begin
          if (!bus.lsb_wr) w_mem_a_nxt = bus.lsb_addr;
        end else if (bus.if_en) begin
          w_mem_a_nxt = bus.if_pc;
        end
      end
      S_READ: begin
        if (w_owner_en) begin
          w_capture = (r_cnt != 7'd0);
          w_cnt_nxt = r_cnt + 7'd1;
          if (w_last) begin
            w_if_done_nxt  = !r_is_lsb;
            w_lsb_done_nxt = r_is_lsb;
          end else if ((r_cnt + 7'd1) != r_len) begin
            w_mem_a_nxt = r_base + 32'(r_cnt) + 32'd1;
          end
        end
      end
      S_WRITE: begin
        if (w_last) begin
          w_lsb_done_nxt = 1'b1;
        end else if (!w_stall) begin
          w_mem_wr_nxt   = 1'b1;
          w_mem_a_nxt    = r_base + 32'(r_cnt);
          w_mem_dout_nxt = r_wdata[{r_cnt[1:0], 3'b000} +: 8];
          w_cnt_nxt      = r_cnt + 7'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt       <= 7'd0;
      r_len       <= 7'd0;
      r_base      <= 32'd0;
      r_wdata     <= 32'd0;
      r_is_lsb    <= 1'b0;
      r_if_data   <= '0;
      r_lsb_rdata <= 32'd0;
      r_if_done   <= 1'b0;
      r_lsb_done  <= 1'b0;
      r_mem_a     <= 32'd0;
      r_mem_dout  <= 8'd0;
      r_mem_wr    <= 1'b0;
    end else if (i_rdy) begin
      r_cnt      <= w_cnt_nxt;
      r_mem_a    <= w_mem_a_nxt;
      r_mem_dout <= w_mem_dout_nxt;
      r_mem_wr   <= w_mem_wr_nxt;
      r_if_done  <= w_if_done_nxt;
      r_lsb_done <= w_lsb_done_nxt;
      if (w_accept) begin
        r_is_lsb <= bus.lsb_en;
        r_base   <= bus.lsb_en ? bus.lsb_addr : bus.if_pc;
        r_len    <= bus.lsb_en ? w_lsb_len : FETCH_LEN;
        r_wdata  <= bus.lsb_wdata;
      end
      // The first load byte clears the upper bytes so shorter loads come back zero-extended.
      if (w_capture) begin
        if (r_is_lsb) begin
          if (r_cnt == 7'd1) r_lsb_rdata <= {24'd0, bus.mem_din};
          else               r_lsb_rdata[{w_byte_idx[1:0], 3'b000} +: 8] <= bus.mem_din;
        end else begin
          r_if_data[{w_byte_idx, 3'b000} +: 8] <= bus.mem_din;
        end
      end
    end
  end

  assign bus.if_done   = r_if_done;
  assign bus.if_data   = r_if_data;
  assign bus.lsb_done  = r_lsb_done;
  assign bus.lsb_rdata = r_lsb_rdata;
  assign bus.mem_a     = r_mem_a;
  assign bus.mem_dout  = r_mem_dout;
  assign bus.mem_wr    = r_mem_wr & i_rdy;
endmodule
